mem_port_arbiter: RTL and testbench

- Parametrised multi-channel front end for the SDRAM controller path.
- Arbitrates NUM_CH independent request ports (CPU access, legacy render, super-res render, command engine) onto one single-issue SDRAM backend.
- Schedules auto-refresh internally instead of relying on an external refresh strobe.
- Returns read data per channel with a one-cycle valid pulse and flags timing faults.

---
 rtl/mem_port_arbiter_if.sv | 42 ++++
 rtl/mem_port_arbiter.sv | 210 +++++++++++++++++++++
 tb/tb_mem_port_arbiter.sv | 253 +++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_port_arbiter_if.sv
// Bundle of the requester-side and SDRAM-backend-side signals of mem_port_arbiter.
// The slave modport is the arbiter's view; master is the requesters plus the backend model.
interface mem_port_arbiter_if #(
    parameter int NUM_CH = 4,
    parameter int ADDR_W = 23
);
    logic [NUM_CH-1:0]        ch_req;
    logic [NUM_CH-1:0]        ch_wr;
    logic [2*NUM_CH-1:0]      ch_size;
    logic [ADDR_W*NUM_CH-1:0] ch_addr;
    logic [32*NUM_CH-1:0]     ch_din;
    logic [NUM_CH-1:0]        ch_ack;
    logic [NUM_CH-1:0]        ch_valid;
    logic [31:0]              ch_dout;
    logic                     mem_rd;
    logic                     mem_wr;
    logic                     mem_refresh;
    logic [ADDR_W-1:0]        mem_addr;
    logic [1:0]               mem_size;
    logic [31:0]              mem_din;
    logic                     mem_enabled;
    logic                     mem_data_ready;
    logic [31:0]              mem_dout;
    logic                     busy;
    logic                     fail;

    modport slave (
        input  ch_req, ch_wr, ch_size, ch_addr, ch_din,
        input  mem_enabled, mem_data_ready, mem_dout,
        output ch_ack, ch_valid, ch_dout,
        output mem_rd, mem_wr, mem_refresh, mem_addr, mem_size, mem_din,
        output busy, fail
    );

    modport master (
        output ch_req, ch_wr, ch_size, ch_addr, ch_din,
        output mem_enabled, mem_data_ready, mem_dout,
        input  ch_ack, ch_valid, ch_dout,
        input  mem_rd, mem_wr, mem_refresh, mem_addr, mem_size, mem_din,
        input  busy, fail
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// Multi-channel SDRAM front end: arbitrates NUM_CH requesters onto one backend and schedules refresh.
// Define MEM_ARB_ROUND_ROBIN_EN for round-robin arbitration; default is fixed priority (channel 0 first).
module mem_port_arbiter #(
    parameter int NUM_CH           = 4,
    parameter int ADDR_W           = 23,
    parameter int OP_CYCLES        = 4,
    parameter int REFRESH_INTERVAL = 405,
    parameter int REFRESH_MAX_PEND = 2
) (
    input  logic              clk,
    input  logic              rst,
    mem_port_arbiter_if.slave bus
);
    localparam int GW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam int RW = (REFRESH_INTERVAL > 1) ? $clog2(REFRESH_INTERVAL) : 1;
    localparam int PW = $clog2(REFRESH_MAX_PEND + 1);
    localparam int OW = $clog2(OP_CYCLES + 1);

    typedef enum logic [2:0] {S_INIT, S_IDLE, S_ISSUE, S_WAIT, S_REFRESH} state_t;

    state_t            state_q, state_d;
    logic [RW-1:0]     rcnt_q, rcnt_d;
    logic [PW-1:0]     pend_q, pend_d;
    logic [OW-1:0]     op_q, op_d;
    logic [GW-1:0]     grant_q, grant_d;
    logic              wr_q, wr_d;
    logic [NUM_CH-1:0] ack_q, ack_d;
    logic [NUM_CH-1:0] valid_q, valid_d;
    logic [31:0]       dout_q, dout_d;
    logic              mem_rd_q, mem_rd_d;
    logic              mem_wr_q, mem_wr_d;
    logic              mem_ref_q, mem_ref_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [1:0]        size_q, size_d;
    logic [31:0]       din_q, din_d;
    logic              fail_q, fail_d;
    logic              wrap, pend_dec, found;
    logic [GW-1:0]     win;

    logic [ADDR_W-1:0] addr_arr [NUM_CH];
    logic [1:0]        size_arr [NUM_CH];
    logic [31:0]       din_arr  [NUM_CH];

    genvar gi;
    generate
        for (gi = 0; gi < NUM_CH; gi++) begin : g_ch
            assign addr_arr[gi] = bus.ch_addr[gi*ADDR_W +: ADDR_W];
            assign size_arr[gi] = bus.ch_size[gi*2 +: 2];
            assign din_arr[gi]  = bus.ch_din[gi*32 +: 32];
        end
    endgenerate

`ifdef MEM_ARB_ROUND_ROBIN_EN
    int rr_idx;

    // Search begins one past the last grant, so every requester is reached within NUM_CH grants.
    always_comb begin
        found  = 1'b0;
        win    = '0;
        rr_idx = 0;
        for (int k = 1; k <= NUM_CH; k++) begin
            rr_idx = int'(grant_q) + k;
            if (rr_idx >= NUM_CH) rr_idx = rr_idx - NUM_CH;
            if (!found && bus.ch_req[rr_idx]) begin
                found = 1'b1;
                win   = GW'(rr_idx);
            end
        end
    end
`else
    always_comb begin
        found = 1'b0;
        win   = '0;
        for (int k = NUM_CH - 1; k >= 0; k--) begin
            if (bus.ch_req[k]) begin
                found = 1'b1;
                win   = GW'(k);
            end
        end
    end
`endif

    always_comb begin
        state_d   = state_q;
        rcnt_d    = rcnt_q;
        pend_d    = pend_q;
        op_d      = op_q;
        grant_d   = grant_q;
        wr_d      = wr_q;
        ack_d     = '0;
        valid_d   = '0;
        dout_d    = dout_q;
        mem_rd_d  = 1'b0;
        mem_wr_d  = 1'b0;
        mem_ref_d = 1'b0;
        addr_d    = addr_q;
        size_d    = size_q;
        din_d     = din_q;
        fail_d    = fail_q;
        wrap      = 1'b0;
        pend_dec  = 1'b0;

        if (state_q != S_INIT) begin
            if (rcnt_q == '0) begin
                rcnt_d = RW'(REFRESH_INTERVAL - 1);
                wrap   = 1'b1;
            end else begin
                rcnt_d = rcnt_q - 1'b1;
            end
        end

        case (state_q)
            S_INIT: begin
                if (bus.mem_enabled) state_d = S_IDLE;
            end
            S_IDLE: begin
                if (pend_q != '0) begin
                    state_d   = S_REFRESH;
                    mem_ref_d = 1'b1;
                    op_d      = OW'(1);
                    pend_dec  = 1'b1;
                end else if (found) begin
                    state_d      = S_ISSUE;
                    grant_d      = win;
                    wr_d         = bus.ch_wr[win];
                    addr_d       = addr_arr[win];
                    size_d       = size_arr[win];
                    din_d        = din_arr[win];
                    ack_d[win]   = 1'b1;
                    mem_rd_d     = ~bus.ch_wr[win];
                    mem_wr_d     = bus.ch_wr[win];
                end
            end
            S_ISSUE: begin
                state_d = S_WAIT;
                op_d    = OW'(1);
            end
            S_WAIT, S_REFRESH: begin
                op_d = op_q + 1'b1;
                if (op_d == OW'(OP_CYCLES)) begin
                    state_d = S_IDLE;
                    // Data is latched and valid pulses even when the backend was late; fail records it.
                    if (state_q == S_WAIT && !wr_q) begin
                        dout_d           = bus.mem_dout;
                        valid_d[grant_q] = 1'b1;
                        if (!bus.mem_data_ready) fail_d = 1'b1;
                    end
                end
            end
            default: state_d = S_INIT;
        endcase

        if (wrap && !pend_dec) begin
            if (pend_q != PW'(REFRESH_MAX_PEND)) pend_d = pend_q + 1'b1;
        end else if (!wrap && pend_dec) begin
            pend_d = pend_q - 1'b1;
        end
        if (pend_d == PW'(REFRESH_MAX_PEND)) fail_d = 1'b1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= S_INIT;
            rcnt_q    <= RW'(REFRESH_INTERVAL - 1);
            pend_q    <= '0;
            op_q      <= '0;
            grant_q   <= GW'(NUM_CH - 1);
            wr_q      <= 1'b0;
            ack_q     <= '0;
            valid_q   <= '0;
            dout_q    <= '0;
            mem_rd_q  <= 1'b0;
            mem_wr_q  <= 1'b0;
            mem_ref_q <= 1'b0;
            addr_q    <= '0;
            size_q    <= '0;
            din_q     <= '0;
            fail_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            rcnt_q    <= rcnt_d;
            pend_q    <= pend_d;
            op_q      <= op_d;
            grant_q   <= grant_d;
            wr_q      <= wr_d;
            ack_q     <= ack_d;
            valid_q   <= valid_d;
            dout_q    <= dout_d;
            mem_rd_q  <= mem_rd_d;
            mem_wr_q  <= mem_wr_d;
            mem_ref_q <= mem_ref_d;
            addr_q    <= addr_d;
            size_q    <= size_d;
            din_q     <= din_d;
            fail_q    <= fail_d;
        end
    end

    assign bus.ch_ack      = ack_q;
    assign bus.ch_valid    = valid_q;
    assign bus.ch_dout     = dout_q;
    assign bus.mem_rd      = mem_rd_q;
    assign bus.mem_wr      = mem_wr_q;
    assign bus.mem_refresh = mem_ref_q;
    assign bus.mem_addr    = addr_q;
    assign bus.mem_size    = size_q;
    assign bus.mem_din     = din_q;
    assign bus.busy        = (state_q != S_IDLE);
    assign bus.fail        = fail_q;
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: three instances cover the main path, refresh period and backlog fault.
// Grant-order expectations follow MEM_ARB_ROUND_ROBIN_EN when it is defined.
module tb_mem_port_arbiter;
    localparam int NCH = 4;
    localparam int AW  = 23;
    localparam int OPC = 4;

    logic clk = 1'b0;
    logic rst_a, rst_b, rst_c;
    always #5 clk = ~clk;

    mem_port_arbiter_if #(.NUM_CH(NCH), .ADDR_W(AW)) if_a (), if_b (), if_c ();

    mem_port_arbiter #(.NUM_CH(NCH), .ADDR_W(AW), .OP_CYCLES(OPC)) u_dut_a (
        .clk(clk), .rst(rst_a), .bus(if_a));
    mem_port_arbiter #(.NUM_CH(NCH), .ADDR_W(AW), .OP_CYCLES(OPC), .REFRESH_INTERVAL(20)) u_dut_b (
        .clk(clk), .rst(rst_b), .bus(if_b));
    mem_port_arbiter #(.NUM_CH(NCH), .ADDR_W(AW), .OP_CYCLES(15), .REFRESH_INTERVAL(8)) u_dut_c (
        .clk(clk), .rst(rst_c), .bus(if_c));

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
            $display("check %s: got 0x%08h exp 0x%08h ok", tag, got, exp);
        end else begin
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic a_set(input int ch, input logic wr, input logic [1:0] sz,
                         input logic [AW-1:0] addr, input logic [31:0] din);
        if_a.ch_wr[ch]            = wr;
        if_a.ch_size[ch*2 +: 2]   = sz;
        if_a.ch_addr[ch*AW +: AW] = addr;
        if_a.ch_din[ch*32 +: 32]  = din;
    endtask

    task automatic a_wait_valid(output int n);
        n = -1;
        for (int i = 1; i <= 30 && n < 0; i++) begin
            tick();
            if (if_a.ch_valid != '0) n = i;
        end
    endtask

    task automatic a_wait_idle();
        for (int i = 0; i < 40 && if_a.busy; i++) tick();
        check_eq("a_idle", 32'(if_a.busy), 0);
    endtask

    initial begin
        int n, k;
        logic [NCH-1:0] seen;
        logic busy_low;
        int ack_t[5];
        int ack_g[5];
        int exp_g[5];
        int rt[$];
        int d1, d2, refs, acks;

        ack_t = '{default: 0};
        ack_g = '{default: 0};
`ifdef MEM_ARB_ROUND_ROBIN_EN
        exp_g = '{0, 1, 2, 3, 0};
`else
        exp_g = '{0, 0, 0, 0, 0};
`endif
        rst_a = 1'b1; rst_b = 1'b1; rst_c = 1'b1;
        if_a.ch_req = '0; if_a.ch_wr = '0; if_a.ch_size = '0; if_a.ch_addr = '0; if_a.ch_din = '0;
        if_a.mem_enabled = 1'b0; if_a.mem_data_ready = 1'b1; if_a.mem_dout = '0;
        if_b.ch_req = '0; if_b.ch_wr = '0; if_b.ch_size = '0; if_b.ch_addr = '0; if_b.ch_din = '0;
        if_b.mem_enabled = 1'b1; if_b.mem_data_ready = 1'b1; if_b.mem_dout = 32'h0000_5A5A;
        if_c.ch_req = '0; if_c.ch_wr = '0; if_c.ch_size = '0; if_c.ch_addr = '0; if_c.ch_din = '0;
        if_c.mem_enabled = 1'b1; if_c.mem_data_ready = 1'b1; if_c.mem_dout = 32'h0000_A5A5;
        repeat (2) tick();

        check_eq("rst_ack",    32'(if_a.ch_ack), 0);
        check_eq("rst_valid",  32'(if_a.ch_valid), 0);
        check_eq("rst_dout",   if_a.ch_dout, 0);
        check_eq("rst_strobe", 32'({if_a.mem_rd, if_a.mem_wr, if_a.mem_refresh}), 0);
        check_eq("rst_busy",   32'(if_a.busy), 1);
        check_eq("rst_fail",   32'(if_a.fail), 0);
        rst_a = 1'b0;

        // INIT hold: request pending but backend not ready
        if_a.ch_req = 4'b0001;
        seen = '0; busy_low = 1'b0;
        for (int i = 0; i < 20; i++) begin
            tick();
            seen     = seen | if_a.ch_ack;
            busy_low = busy_low | ~if_a.busy;
        end
        check_eq("init_no_ack", 32'(seen), 0);
        check_eq("init_busy_low", 32'(busy_low), 0);
        if_a.mem_enabled = 1'b1;
        n = 0;
        for (int i = 1; i <= 4 && n == 0; i++) begin
            tick();
            if (if_a.ch_ack != '0) n = i;
        end
        check_eq("init_ack", 32'(if_a.ch_ack), 32'h1);
        check_eq("init_ack_lat_le2", 32'(n >= 1 && n <= 2), 1);
        if_a.ch_req = '0;
        a_wait_idle();

        // Single read on channel 1
        a_set(1, 1'b0, 2'b01, 23'h000104, 32'h0);
        if_a.mem_dout = 32'hDEADBEEF;
        if_a.ch_req = 4'b0010;
        tick();
        check_eq("rd_ack",      32'(if_a.ch_ack), 32'h2);
        check_eq("rd_mem_rd",   32'(if_a.mem_rd), 1);
        check_eq("rd_mem_addr", 32'(if_a.mem_addr), 32'h104);
        check_eq("rd_mem_size", 32'(if_a.mem_size), 1);
        if_a.ch_req = '0;
        tick();
        check_eq("rd_strobe_1cyc", 32'(if_a.mem_rd), 0);
        a_wait_valid(n);
        check_eq("rd_valid_lat", 32'(n + 1), OPC);
        check_eq("rd_valid",     32'(if_a.ch_valid), 32'h2);
        check_eq("rd_dout",      if_a.ch_dout, 32'hDEADBEEF);

        // Single write on channel 2: no valid pulse
        a_set(2, 1'b1, 2'b10, 23'h000ABC, 32'h12345678);
        if_a.ch_req = 4'b0100;
        tick();
        check_eq("wr_ack",     32'(if_a.ch_ack), 32'h4);
        check_eq("wr_mem_wr",  32'({if_a.mem_wr, if_a.mem_rd}), 32'h2);
        check_eq("wr_mem_din", if_a.mem_din, 32'h12345678);
        if_a.ch_req = '0;
        seen = '0;
        for (int i = 0; i < 6; i++) begin
            tick();
            seen = seen | if_a.ch_valid;
        end
        check_eq("wr_no_valid", 32'(seen), 0);
        a_set(2, 1'b0, 2'b10, 23'h000ABC, 32'h12345678);

        // Contention from a fresh reset, all four channels reading
        rst_a = 1'b1;
        tick();
        rst_a = 1'b0;
        if_a.ch_req = 4'b1111;
        k = 0;
        for (int i = 0; i < 40 && k < 5; i++) begin
            tick();
            if (if_a.ch_ack != '0) begin
                ack_t[k] = i;
                ack_g[k] = -1;
                for (int c = 0; c < NCH; c++) if (if_a.ch_ack[c]) ack_g[k] = c;
                k++;
            end
        end
        if_a.ch_req = '0;
        for (int j = 0; j < 5; j++) check_eq($sformatf("cont_grant%0d", j), 32'(ack_g[j]), 32'(exp_g[j]));
        for (int j = 0; j < 4; j++) check_eq($sformatf("cont_gap%0d", j), 32'(ack_t[j+1] - ack_t[j]), OPC + 1);
        a_wait_idle();

        // Late backend data: valid still pulses, fail latches
        if_a.mem_data_ready = 1'b0;
        if_a.mem_dout = 32'hCAFEF00D;
        a_set(3, 1'b0, 2'b10, 23'h000200, 32'h0);
        if_a.ch_req = 4'b1000;
        tick();
        if_a.ch_req = '0;
        a_wait_valid(n);
        check_eq("late_valid", 32'(if_a.ch_valid), 32'h8);
        check_eq("late_dout",  if_a.ch_dout, 32'hCAFEF00D);
        check_eq("late_fail",  32'(if_a.fail), 1);
        if_a.mem_data_ready = 1'b1;
        if_a.ch_req = 4'b0001;
        tick();
        if_a.ch_req = '0;
        a_wait_valid(n);
        check_eq("fail_sticky", 32'(if_a.fail), 1);

        // Reset in the middle of WAIT
        if_a.ch_req = 4'b0010;
        tick();
        if_a.ch_req = '0;
        tick();
        tick();
        rst_a = 1'b1;
        #1;
        check_eq("mid_ack",     32'(if_a.ch_ack), 0);
        check_eq("mid_valid",   32'(if_a.ch_valid), 0);
        check_eq("mid_dout",    if_a.ch_dout, 0);
        check_eq("mid_strobe",  32'({if_a.mem_rd, if_a.mem_wr, if_a.mem_refresh}), 0);
        check_eq("mid_addr",    32'(if_a.mem_addr), 0);
        check_eq("mid_busy",    32'(if_a.busy), 1);
        check_eq("mid_fail",    32'(if_a.fail), 0);
        if_a.mem_enabled = 1'b0;
        tick();
        tick();
        rst_a = 1'b0;
        seen = '0; busy_low = 1'b0;
        for (int i = 0; i < 8; i++) begin
            tick();
            seen     = seen | if_a.ch_valid | if_a.ch_ack;
            busy_low = busy_low | ~if_a.busy;
        end
        check_eq("mid_no_pulse", 32'(seen), 0);
        check_eq("mid_stays_init", 32'(busy_low), 0);

        // Refresh period with REFRESH_INTERVAL=20, no traffic
        rst_b = 1'b0;
        for (int i = 0; i < 75; i++) begin
            tick();
            if (if_b.mem_refresh) rt.push_back(i);
        end
        d1 = (rt.size() >= 2) ? rt[1] - rt[0] : -1;
        d2 = (rt.size() >= 3) ? rt[2] - rt[1] : -1;
        check_eq("ref_count", 32'(rt.size()), 3);
        check_eq("ref_period0", 32'(d1), 20);
        check_eq("ref_period1", 32'(d2), 20);
        check_eq("ref_fail", 32'(if_b.fail), 0);

        // Refresh keeps being inserted under continuous channel-0 reads
        if_b.ch_req = 4'b0001;
        refs = 0; acks = 0;
        for (int i = 0; i < 80; i++) begin
            tick();
            if (if_b.mem_refresh) refs++;
            if (if_b.ch_ack[0]) acks++;
        end
        if_b.ch_req = '0;
        check_eq("traffic_refs", 32'(refs >= 3 && refs <= 5), 1);
        check_eq("traffic_acks", 32'(acks >= 10 && acks <= 14), 1);
        check_eq("traffic_fail", 32'(if_b.fail), 0);

        // Refresh backlog: OP_CYCLES=15 against a refresh every 8 cycles
        rst_c = 1'b0;
        if_c.ch_req = 4'b0001;
        repeat (3) tick();
        check_eq("backlog_fail_early", 32'(if_c.fail), 0);
        for (int i = 0; i < 200 && !if_c.fail; i++) tick();
        check_eq("backlog_fail", 32'(if_c.fail), 1);
        repeat (20) tick();
        check_eq("backlog_fail_sticky", 32'(if_c.fail), 1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
